arm_core: RTL and testbench
===========================

ARM_CORE -- requirements
Module: arm_core

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address loaded into PC on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 clears state immediately, independent of clk.
REQ-004 PC  output  32  instruction fetch address, registered.
REQ-005 Instruction  input  32  instruction at PC, valid combinationally within the same cycle.
REQ-006 write_enable  output  1  data-memory write strobe, combinational.
REQ-007 ALUResult  output  32  ALU result; also the data-memory address for loads/stores.
REQ-008 WriteData  output  32  store data, equal to Rd.
REQ-009 ReadData  input  32  load data for address ALUResult, valid in the same cycle and sampled at the rising edge that retires the load.

Function
REQ-010 The core SHALL be single-cycle: one instruction per clock, with PC and register file updates on the same edge.
REQ-011 PC SHALL advance as follows: PC+4 by default; branch target on a taken branch; ALUResult when a data-processing instruction or load writes R15.
REQ-012 The register file SHALL hold R0-R14 with two combinational read ports and one write port; reading R15 SHALL return PC+8.
REQ-013 Decode SHALL use the standard ARM fields: cond[31:28], op[27:26], I[25], cmd[24:21], S[20], Rn[19:16], Rd[15:12], Src2[11:0].
REQ-014 The condition check SHALL support all ARM codes 0000-1110 against flags NZCV; code 1111 SHALL be treated as always.
REQ-015 On condition fail, the instruction SHALL be a no-op: no register, flag or PC-redirect update, write_enable=0, PC+4.
REQ-016 For data processing (op=00), cmd SHALL select: AND 0000, EOR 0001, SUB 0010, RSB 0011, ADD 0100, ORR 1100, MOV 1101, CMP 1010.
- CMP SHALL write no register and SHALL always update flags.
REQ-017 Src2 with I=1 SHALL be imm8 rotated right by 2*rot[11:8].
REQ-018 Src2 with I=0 SHALL be Rm[3:0] shifted by shamt5[11:7] with sh[6:5]: LSL, LSR, ASR, ROR; LSR/ASR with shamt 0 act as shift by 32.
REQ-019 Flags SHALL update only when S=1 (or CMP) and the condition passes:
- N = result[31], Z = (result==0).
- ADD/SUB/RSB/CMP: C = adder carry-out, with SUB carry = NOT borrow; V = signed overflow.
- Logical ops and MOV: C = shifter carry-out; V unchanged.
REQ-020 For memory (op=01), ALUResult SHALL be Rn ± offset, with U[23]=1 add and U[23]=0 subtract.
- Offset is imm12 when I=0, or shifted Rm when I=1.
- Offset addressing only; P, W and B are ignored.
REQ-021 STR (L=0, condition passes) SHALL drive write_enable=1 and WriteData=Rd.
REQ-022 LDR (L=1) SHALL write ReadData into Rd at the edge.
REQ-023 For branch (op=10), the target SHALL be PC+8+(sign-extended imm24<<2).
- Bit24=1 (BL) SHALL also write R14=PC+4.
REQ-024 op=11 SHALL execute as a no-op that advances PC by 4.
REQ-025 All arithmetic SHALL be 32-bit modulo 2^32.
REQ-026 write_enable SHALL be 0 for every non-store instruction.

Reset
REQ-027 While reset=0, the following SHALL be forced:
- PC = RESET_PC.
- R0-R14 = 0.
- NZCV = 0.
- write_enable = 0.
REQ-028 Reset asserted mid-cycle SHALL abort the current instruction with no register or flag write; execution SHALL resume at RESET_PC on the first rising edge after reset=1.

Verification
REQ-029 Pulse reset=0, then release; drive Instruction=E1A00000 (MOV R0,R0) -> PC=0, then 4, 8, 12 on successive edges; write_enable=0 throughout.
REQ-030 Drive E2801005, E2812003, E5802010 in sequence -> R1=5, R2=8; during the STR cycle write_enable=1, ALUResult=0x10, WriteData=8.
REQ-031 With ReadData=DEADBEEF, drive E5903010 then E2834000 -> ALUResult=0x10 during the LDR cycle, then ALUResult=DEADBEEF.
REQ-032 With R1=5, drive E0515001 (SUBS R5,R1,R1), then 0A000000 (BEQ) at PC=X -> Z=1, C=1, R5=0, next PC=X+8; 1A000000 (BNE) at PC=Y -> next PC=Y+4.
REQ-033 With Z=0, drive 00000000 (ANDEQ), and with Z=1 drive 15802010 (STRNE) -> no register writes, write_enable=0, PC+4 each.
REQ-034 Assert reset=0 between clock edges after several instructions -> PC=RESET_PC and all flags 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/arm_core.sv
// Single-cycle ARM subset core: data processing, LDR/STR, B/BL.
// Ports: clk, reset (async low), PC, Instruction, write_enable,
//        ALUResult, WriteData, ReadData.
module arm_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] Instruction,
  output logic        write_enable,
  output logic [31:0] ALUResult,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_EOR = 4'b0001;
  localparam logic [3:0] C_SUB = 4'b0010;
  localparam logic [3:0] C_RSB = 4'b0011;
  localparam logic [3:0] C_ADD = 4'b0100;
  localparam logic [3:0] C_CMP = 4'b1010;
  localparam logic [3:0] C_ORR = 4'b1100;
  localparam logic [3:0] C_MOV = 4'b1101;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [16];
  logic [3:0]  nzcv_q, nzcv_d;

  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;

  logic [3:0]  cond, cmd, rn, rd;
  logic [1:0]  op, sh_type;
  logic        ibit, sbit, ubit, lbit, blbit;
  logic [4:0]  shamt;
  logic        fn, fz, fc, fv;

  assign cond    = Instruction[31:28];
  assign op      = Instruction[27:26];
  assign ibit    = Instruction[25];
  assign cmd     = Instruction[24:21];
  assign blbit   = Instruction[24];
  assign ubit    = Instruction[23];
  assign sbit    = Instruction[20];
  assign lbit    = Instruction[20];
  assign rn      = Instruction[19:16];
  assign rd      = Instruction[15:12];
  assign shamt   = Instruction[11:7];
  assign sh_type = Instruction[6:5];
  assign {fn, fz, fc, fv} = nzcv_q;

  logic [31:0] pc4, pc8;
  assign pc4 = pc_q + 32'd4;
  assign pc8 = pc_q + 32'd8;

  // R15 reads as the address of the current instruction plus 8
  logic [31:0] rn_v, rm_v, rd_v;
  assign rn_v = (rn == 4'hF) ? pc8 : rf_q[rn];
  assign rm_v = (Instruction[3:0] == 4'hF) ? pc8 : rf_q[Instruction[3:0]];
  assign rd_v = (rd == 4'hF) ? pc8 : rf_q[rd];

  logic pass;
  always_comb begin
    case (cond)
      4'h0:    pass = fz;
      4'h1:    pass = !fz;
      4'h2:    pass = fc;
      4'h3:    pass = !fc;
      4'h4:    pass = fn;
      4'h5:    pass = !fn;
      4'h6:    pass = fv;
      4'h7:    pass = !fv;
      4'h8:    pass = fc && !fz;
      4'h9:    pass = !fc || fz;
      4'hA:    pass = (fn == fv);
      4'hB:    pass = (fn != fv);
      4'hC:    pass = !fz && (fn == fv);
      4'hD:    pass = fz || (fn != fv);
      default: pass = 1'b1;
    endcase
  end

  // Immediate-shifted register; LSR/ASR by 0 encode a shift by 32
  logic [31:0] sh_res;
  logic        sh_c;
  logic [32:0] t33;
  logic [5:0]  n6;
  always_comb begin
    sh_res = rm_v;
    sh_c   = fc;
    t33    = '0;
    n6     = (shamt == 5'd0) ? 6'd32 : {1'b0, shamt};
    case (sh_type)
      2'b00: if (shamt != 5'd0) begin
        t33    = {1'b0, rm_v} << shamt;
        sh_res = t33[31:0];
        sh_c   = t33[32];
      end
      2'b01: begin
        t33    = {rm_v, 1'b0} >> n6;
        sh_res = t33[32:1];
        sh_c   = t33[0];
      end
      2'b10: begin
        t33    = $unsigned($signed({rm_v, 1'b0}) >>> n6);
        sh_res = t33[32:1];
        sh_c   = t33[0];
      end
      default: if (shamt != 5'd0) begin
        sh_res = (rm_v >> shamt) | (rm_v << (6'd32 - {1'b0, shamt}));
        sh_c   = sh_res[31];
      end
    endcase
  end

  logic [4:0]  rot;
  logic [31:0] imm8, imm_res;
  logic        imm_c;
  assign rot     = {Instruction[11:8], 1'b0};
  assign imm8    = {24'd0, Instruction[7:0]};
  assign imm_res = (imm8 >> rot) | (imm8 << (6'd32 - {1'b0, rot}));
  assign imm_c   = (rot == 5'd0) ? fc : imm_res[31];

  logic [31:0] src2;
  logic        src_c;
  assign src2  = ibit ? imm_res : sh_res;
  assign src_c = ibit ? imm_c : sh_c;

  logic [31:0] alu_y;
  logic        alu_c, alu_v, alu_wr, alu_ok;
  logic [32:0] sum;
  always_comb begin
    alu_y  = '0;
    alu_c  = src_c;
    alu_v  = fv;
    alu_wr = 1'b1;
    alu_ok = 1'b1;
    sum    = '0;
    case (cmd)
      C_AND: alu_y = rn_v & src2;
      C_EOR: alu_y = rn_v ^ src2;
      C_ORR: alu_y = rn_v | src2;
      C_MOV: alu_y = src2;
      C_ADD: begin
        sum   = {1'b0, rn_v} + {1'b0, src2};
        alu_y = sum[31:0];
        alu_c = sum[32];
        alu_v = (rn_v[31] == src2[31]) && (alu_y[31] != rn_v[31]);
      end
      C_SUB, C_CMP: begin
        sum    = {1'b0, rn_v} + {1'b0, ~src2} + 33'd1;
        alu_y  = sum[31:0];
        alu_c  = sum[32];
        alu_v  = (rn_v[31] != src2[31]) && (alu_y[31] != rn_v[31]);
        alu_wr = (cmd != C_CMP);
      end
      C_RSB: begin
        sum   = {1'b0, src2} + {1'b0, ~rn_v} + 33'd1;
        alu_y = sum[31:0];
        alu_c = sum[32];
        alu_v = (src2[31] != rn_v[31]) && (alu_y[31] != src2[31]);
      end
      default: begin
        alu_wr = 1'b0;
        alu_ok = 1'b0;
      end
    endcase
  end

  logic [31:0] offs, maddr, target;
  assign offs   = ibit ? sh_res : {20'd0, Instruction[11:0]};
  assign maddr  = ubit ? (rn_v + offs) : (rn_v - offs);
  assign target = pc8 + {{6{Instruction[23]}}, Instruction[23:0], 2'b00};

  always_comb begin
    case (op)
      2'b00:   ALUResult = alu_y;
      2'b01:   ALUResult = maddr;
      2'b10:   ALUResult = target;
      default: ALUResult = '0;
    endcase
  end

  assign WriteData    = rd_v;
  assign write_enable = reset && pass && (op == 2'b01) && !lbit;
  assign PC           = pc_q;

  always_comb begin
    pc_d   = pc4;
    nzcv_d = nzcv_q;
    rf_we  = 1'b0;
    rf_wa  = rd;
    rf_wd  = alu_y;
    if (pass) begin
      case (op)
        2'b00: begin
          if (alu_wr) begin
            if (rd == 4'hF) pc_d = alu_y;
            else rf_we = 1'b1;
          end
          if (alu_ok && (sbit || cmd == C_CMP))
            nzcv_d = {alu_y[31], alu_y == 32'd0, alu_c, alu_v};
        end
        2'b01: if (lbit) begin
          rf_wd = ReadData;
          if (rd == 4'hF) pc_d = maddr;
          else rf_we = 1'b1;
        end
        2'b10: begin
          pc_d = target;
          if (blbit) begin
            rf_we = 1'b1;
            rf_wa = 4'd14;
            rf_wd = pc4;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      nzcv_q <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      nzcv_q <= nzcv_d;
      if (rf_we) rf_q[rf_wa] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_arm_core.sv
// Directed testbench for arm_core.
// Drives instructions after each rising edge and checks before the next.
module tb_arm_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        write_enable;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  int tests = 0;
  int fails = 0;
  logic [31:0] pc_m;

  arm_core #(.RESET_PC(32'h0)) dut (
    .clk(clk),
    .reset(reset),
    .PC(PC),
    .Instruction(Instruction),
    .write_enable(write_enable),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData(ReadData)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins);
    Instruction = ins;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    Instruction = 32'hE1A00000;
    ReadData = 32'h0;
    #3;
    tests++;
    if (PC !== 32'h0) begin
      fails++;
      $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0);
    end
    tests++;
    if (write_enable !== 1'b0) begin
      fails++;
      $display("FAIL reset_we got=%b exp=0", write_enable);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    pc_m = 32'h0;
    tests++;
    if (PC !== pc_m) begin
      fails++;
      $display("FAIL release_pc got=%h exp=%h", PC, pc_m);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      pc_m = pc_m + 32'd4;
      tests++;
      if (PC !== pc_m || write_enable !== 1'b0) begin
        fails++;
        $display("FAIL nop_seq pc=%h we=%b exp pc=%h we=0",
                 PC, write_enable, pc_m);
      end
    end
  endtask

  task automatic test_alu_store();
    drive(32'hE2801005);
    tests++;
    if (ALUResult !== 32'd5) begin
      fails++;
      $display("FAIL add_imm got=%h exp=%h", ALUResult, 32'd5);
    end
    tick(); pc_m = pc_m + 32'd4;
    drive(32'hE2812003);
    tests++;
    if (ALUResult !== 32'd8) begin
      fails++;
      $display("FAIL add_reg got=%h exp=%h", ALUResult, 32'd8);
    end
    tick(); pc_m = pc_m + 32'd4;
    drive(32'hE5802010);
    tests++;
    if (write_enable !== 1'b1 || ALUResult !== 32'h10
        || WriteData !== 32'd8) begin
      fails++;
      $display("FAIL str we=%b addr=%h wd=%h exp we=1 addr=10 wd=8",
               write_enable, ALUResult, WriteData);
    end
    tick(); pc_m = pc_m + 32'd4;
    drive(32'hE1A09102);
    tests++;
    if (ALUResult !== 32'd32 || write_enable !== 1'b0) begin
      fails++;
      $display("FAIL mov_lsl got=%h we=%b exp=%h we=0",
               ALUResult, write_enable, 32'd32);
    end
    tick(); pc_m = pc_m + 32'd4;
    drive(32'hE3A0A4FF);
    tests++;
    if (ALUResult !== 32'hFF000000) begin
      fails++;
      $display("FAIL imm_rot got=%h exp=%h", ALUResult, 32'hFF000000);
    end
    tick(); pc_m = pc_m + 32'd4;
    tests++;
    if (PC !== pc_m) begin
      fails++;
      $display("FAIL alu_pc got=%h exp=%h", PC, pc_m);
    end
  endtask

  task automatic test_load();
    ReadData = 32'hDEADBEEF;
    drive(32'hE5903010);
    tests++;
    if (ALUResult !== 32'h10 || write_enable !== 1'b0) begin
      fails++;
      $display("FAIL ldr_addr got=%h we=%b exp=10 we=0",
               ALUResult, write_enable);
    end
    tick(); pc_m = pc_m + 32'd4;
    drive(32'hE2834000);
    tests++;
    if (ALUResult !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL ldr_data got=%h exp=%h", ALUResult, 32'hDEADBEEF);
    end
    tick(); pc_m = pc_m + 32'd4;
    drive(32'hE5113004);
    tests++;
    if (ALUResult !== 32'd1) begin
      fails++;
      $display("FAIL ldr_sub got=%h exp=%h", ALUResult, 32'd1);
    end
    tick(); pc_m = pc_m + 32'd4;
  endtask

  task automatic test_branch();
    logic [31:0] y;
    drive(32'hE0515001);
    tests++;
    if (ALUResult !== 32'd0) begin
      fails++;
      $display("FAIL subs got=%h exp=0", ALUResult);
    end
    tick(); pc_m = pc_m + 32'd4;
    drive(32'hE2856000);
    tests++;
    if (ALUResult !== 32'd0) begin
      fails++;
      $display("FAIL r5_zero got=%h exp=0", ALUResult);
    end
    tick(); pc_m = pc_m + 32'd4;
    drive(32'h0A000000);
    tick(); pc_m = pc_m + 32'd8;
    tests++;
    if (PC !== pc_m) begin
      fails++;
      $display("FAIL beq_taken got=%h exp=%h", PC, pc_m);
    end
    drive(32'h2A000000);
    tick(); pc_m = pc_m + 32'd8;
    tests++;
    if (PC !== pc_m) begin
      fails++;
      $display("FAIL bcs_taken got=%h exp=%h", PC, pc_m);
    end
    drive(32'h1A000000);
    tick(); pc_m = pc_m + 32'd4;
    tests++;
    if (PC !== pc_m) begin
      fails++;
      $display("FAIL bne_not got=%h exp=%h", PC, pc_m);
    end
    drive(32'hEA000002);
    tick(); pc_m = pc_m + 32'd16;
    tests++;
    if (PC !== pc_m) begin
      fails++;
      $display("FAIL b_fwd got=%h exp=%h", PC, pc_m);
    end
    y = pc_m;
    drive(32'hEBFFFFFE);
    tick();
    tests++;
    if (PC !== y) begin
      fails++;
      $display("FAIL bl_back got=%h exp=%h", PC, y);
    end
    drive(32'hE1A0B00E);
    tests++;
    if (ALUResult !== y + 32'd4) begin
      fails++;
      $display("FAIL bl_link got=%h exp=%h", ALUResult, y + 32'd4);
    end
    tick(); pc_m = y + 32'd4;
    drive(32'hE1A0B00F);
    tests++;
    if (ALUResult !== pc_m + 32'd8) begin
      fails++;
      $display("FAIL r15_read got=%h exp=%h", ALUResult, pc_m + 32'd8);
    end
    tick(); pc_m = pc_m + 32'd4;
  endtask

  task automatic test_cmp();
    drive(32'hE3510006);
    tests++;
    if (ALUResult !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL cmp_res got=%h exp=%h", ALUResult, 32'hFFFFFFFF);
    end
    tick(); pc_m = pc_m + 32'd4;
    drive(32'hBA000000);
    tick(); pc_m = pc_m + 32'd8;
    tests++;
    if (PC !== pc_m) begin
      fails++;
      $display("FAIL blt_taken got=%h exp=%h", PC, pc_m);
    end
    drive(32'h3A000000);
    tick(); pc_m = pc_m + 32'd8;
    tests++;
    if (PC !== pc_m) begin
      fails++;
      $display("FAIL bcc_taken got=%h exp=%h", PC, pc_m);
    end
    drive(32'h5A000000);
    tick(); pc_m = pc_m + 32'd4;
    tests++;
    if (PC !== pc_m) begin
      fails++;
      $display("FAIL bpl_not got=%h exp=%h", PC, pc_m);
    end
  endtask

  task automatic test_condfail();
    drive(32'h00000000);
    tests++;
    if (write_enable !== 1'b0) begin
      fails++;
      $display("FAIL andeq_we got=%b exp=0", write_enable);
    end
    tick(); pc_m = pc_m + 32'd4;
    tests++;
    if (PC !== pc_m) begin
      fails++;
      $display("FAIL andeq_pc got=%h exp=%h", PC, pc_m);
    end
    drive(32'h02810005);
    tick(); pc_m = pc_m + 32'd4;
    drive(32'hE1A08000);
    tests++;
    if (ALUResult !== 32'd0) begin
      fails++;
      $display("FAIL addeq_skip got=%h exp=0", ALUResult);
    end
    tick(); pc_m = pc_m + 32'd4;
    drive(32'hE0515001);
    tick(); pc_m = pc_m + 32'd4;
    drive(32'h15802010);
    tests++;
    if (write_enable !== 1'b0) begin
      fails++;
      $display("FAIL strne_we got=%b exp=0", write_enable);
    end
    tick(); pc_m = pc_m + 32'd4;
    tests++;
    if (PC !== pc_m) begin
      fails++;
      $display("FAIL strne_pc got=%h exp=%h", PC, pc_m);
    end
    drive(32'h12907001);
    tick(); pc_m = pc_m + 32'd4;
    drive(32'h0A000000);
    tick(); pc_m = pc_m + 32'd8;
    tests++;
    if (PC !== pc_m) begin
      fails++;
      $display("FAIL flags_kept got=%h exp=%h", PC, pc_m);
    end
  endtask

  task automatic test_async_reset();
    drive(32'hE5802010);
    tests++;
    if (write_enable !== 1'b1) begin
      fails++;
      $display("FAIL pre_rst_we got=%b exp=1", write_enable);
    end
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if (PC !== 32'h0 || write_enable !== 1'b0) begin
      fails++;
      $display("FAIL async_rst pc=%h we=%b exp pc=0 we=0",
               PC, write_enable);
    end
    tick();
    tests++;
    if (PC !== 32'h0) begin
      fails++;
      $display("FAIL rst_hold got=%h exp=0", PC);
    end
    @(negedge clk);
    Instruction = 32'h0A000000;
    reset = 1'b1;
    pc_m = 32'h0;
    tick(); pc_m = pc_m + 32'd4;
    tests++;
    if (PC !== pc_m) begin
      fails++;
      $display("FAIL z_cleared got=%h exp=%h", PC, pc_m);
    end
    drive(32'h2A000000);
    tick(); pc_m = pc_m + 32'd4;
    tests++;
    if (PC !== pc_m) begin
      fails++;
      $display("FAIL c_cleared got=%h exp=%h", PC, pc_m);
    end
    drive(32'hE2810000);
    tests++;
    if (ALUResult !== 32'd0) begin
      fails++;
      $display("FAIL rf_cleared got=%h exp=0", ALUResult);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_store();
    test_load();
    test_branch();
    test_cmp();
    test_condfail();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
